// File: rtl/moore_seq_detector.sv
// ---------------------------------------------------------------------------
// moore_seq_detector
//   Parametrised Moore serial pattern detector. One bit is accepted on x per
//   clock edge with en=1. y is high while the most recent LEN accepted bits
//   equal PATTERN. PATTERN[LEN-1] is the first bit of the pattern to arrive.
//   State k is the length of the longest pattern prefix that is a suffix of
//   the accepted history. State LEN is the single accepting state.
//   The next-state table is built at elaboration from PATTERN with the KMP
//   failure rule. No pattern is hand coded.
//
// Parameters
//   LEN      pattern length, 1..32
//   PATTERN  pattern bits; the MSB arrives first
//   OVERLAP  1: matches may overlap; 0: history is cleared after a match
//   CNT_W    match counter width, 1..32
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   en         in   bit-valid qualifier; x is sampled only when en=1
//   x          in   serial input bit
//   y          out  match flag, registered, equal to (state == LEN)
//   state      out  matched prefix length, 0..LEN
//   match_cnt  out  saturating count of matches
//
// Build option
//   SEQ_DET_CNT_EN  when defined, match_cnt counts matches and saturates at
//                   all-ones. When undefined, there are no counter flops and
//                   match_cnt is tied to 0. The port list is the same in both
//                   builds.
// ---------------------------------------------------------------------------
module moore_seq_detector #(
  parameter int              LEN     = 3,
  parameter logic [LEN-1:0]  PATTERN = 3'b101,
  parameter bit              OVERLAP = 1'b1,
  parameter int              CNT_W   = 8,
  localparam int             SW      = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  output logic             y,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int            NS  = 2 ** SW;
  localparam logic [SW-1:0] ACC = SW'(LEN);

  // Next state from prefix length k on input bit xb.
  // Let s = P(0..k-1) followed by xb. The result is the longest prefix of the
  // pattern (at most LEN bits) that is a suffix of s.
  // For k < LEN, a full extension (k+1) is found when xb == P(k). Otherwise
  // the search falls back through the shorter borders.
  // Codes above LEN cannot be reached. They return 0 so the table is total.
  function automatic int next_fn(input int k, input logic xb);
    int   res;
    int   idx;
    logic ok;
    logic sb;
    res = 0;
    if (k > LEN) return 0;
    if (k == LEN && !OVERLAP) return (xb == PATTERN[LEN-1]) ? 1 : 0;
    for (int j = 1; j <= LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++) begin
          idx = k + 1 - j + t;
          sb  = (idx < k) ? PATTERN[LEN-1-idx] : xb;
          if (sb != PATTERN[LEN-1-t]) ok = 1'b0;
        end
        if (ok) res = j;
      end
    end
    return res;
  endfunction

  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];

  for (genvar k = 0; k < NS; k++) begin : g_tbl
    assign nxt0[k] = SW'(next_fn(k, 1'b0));
    assign nxt1[k] = SW'(next_fn(k, 1'b1));
  end

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic          y_q;

  assign state_d = x ? nxt1[state_q] : nxt0[state_q];

  // y is registered beside the state. It is decoded from the next state, so
  // it always equals (state_q == LEN).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      y_q     <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      y_q     <= (state_d == ACC);
    end
  end

  assign state = state_q;
  assign y     = y_q;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // The counter stops at all-ones and is cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en && (state_d == ACC) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
module tb_moore_seq_detector;

  localparam bit CNT_ON =
`ifdef SEQ_DET_CNT_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic x   = 1'b0;

  int ncmp = 0;
  int nerr = 0;

  // Instance u_ov: LEN=3, PATTERN=101, OVERLAP=1, CNT_W=8
  logic       y_ov;
  logic [1:0] st_ov;
  logic [7:0] cnt_ov;
  // Instance u_no: LEN=3, PATTERN=101, OVERLAP=0
  logic       y_no;
  logic [1:0] st_no;
  logic [7:0] cnt_no;
  // Instance u_a7: LEN=8, PATTERN=A7, OVERLAP=1
  logic       y_a7;
  logic [3:0] st_a7;
  logic [7:0] cnt_a7;
  // Instance u_sat: LEN=3, PATTERN=101, OVERLAP=1, CNT_W=2
  logic       y_sat;
  logic [1:0] st_sat;
  logic [1:0] cnt_sat;
  // Instance u_one: LEN=1, PATTERN=1
  logic       y_one;
  logic       st_one;
  logic [7:0] cnt_one;

  moore_seq_detector #(.LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .en(en), .x(x), .y(y_ov), .state(st_ov), .match_cnt(cnt_ov));
  moore_seq_detector #(.LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .rst(rst), .en(en), .x(x), .y(y_no), .state(st_no), .match_cnt(cnt_no));
  moore_seq_detector #(.LEN(8), .PATTERN(8'hA7), .OVERLAP(1'b1), .CNT_W(8)) u_a7 (
    .clk(clk), .rst(rst), .en(en), .x(x), .y(y_a7), .state(st_a7), .match_cnt(cnt_a7));
  moore_seq_detector #(.LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .x(x), .y(y_sat), .state(st_sat), .match_cnt(cnt_sat));
  moore_seq_detector #(.LEN(1), .PATTERN(1'b1), .OVERLAP(1'b1), .CNT_W(8)) u_one (
    .clk(clk), .rst(rst), .en(en), .x(x), .y(y_one), .state(st_one), .match_cnt(cnt_one));

  always #5 clk = ~clk;

  // Inputs change on the falling edge. Outputs are sampled 1 ns after the
  // rising edge.
  task automatic step(input logic b, input logic e);
    @(negedge clk);
    x  = b;
    en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    x   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    x   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ncmp++; if (st_ov !== 2'd0) begin nerr++; $display("FAIL reset_state got %0d want 0", st_ov); end
    ncmp++; if (y_ov !== 1'b0) begin nerr++; $display("FAIL reset_y got %b want 0", y_ov); end
    ncmp++; if (cnt_ov !== 8'd0) begin nerr++; $display("FAIL reset_cnt got %0d want 0", cnt_ov); end
    ncmp++; if (st_a7 !== 4'd0 || y_a7 !== 1'b0) begin nerr++; $display("FAIL reset_a7 got st=%0d y=%b want 0/0", st_a7, y_a7); end
    ncmp++; if (y_one !== 1'b0) begin nerr++; $display("FAIL reset_len1_y got %b want 0", y_one); end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
  endtask

  // Stream 1,0,1,0,1 is applied to both overlap modes.
  task automatic test_overlap_modes();
    logic [4:0] bits;
    logic [1:0] e_ov [5];
    logic [1:0] e_no [5];
    bits = 5'b10101;
    e_ov = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
    e_no = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(bits[4-i], 1'b1);
      ncmp++; if (st_ov !== e_ov[i]) begin nerr++; $display("FAIL ov_state bit%0d got %0d want %0d", i+1, st_ov, e_ov[i]); end
      ncmp++; if (y_ov !== (e_ov[i] == 2'd3)) begin nerr++; $display("FAIL ov_y bit%0d got %b want %b", i+1, y_ov, e_ov[i] == 2'd3); end
      ncmp++; if (st_no !== e_no[i]) begin nerr++; $display("FAIL no_state bit%0d got %0d want %0d", i+1, st_no, e_no[i]); end
      ncmp++; if (y_no !== (e_no[i] == 2'd3)) begin nerr++; $display("FAIL no_y bit%0d got %b want %b", i+1, y_no, e_no[i] == 2'd3); end
    end
    ncmp++; if (cnt_ov !== (CNT_ON ? 8'd2 : 8'd0)) begin nerr++; $display("FAIL ov_cnt got %0d want %0d", cnt_ov, CNT_ON ? 2 : 0); end
    ncmp++; if (cnt_no !== (CNT_ON ? 8'd1 : 8'd0)) begin nerr++; $display("FAIL no_cnt got %0d want %0d", cnt_no, CNT_ON ? 1 : 0); end
  endtask

  // In 1,0,0,1,0,1 the "1001" part must not match. The LEN=1 detector
  // follows each accepted bit.
  task automatic test_no_false_match();
    logic [5:0] bits;
    logic [1:0] e_st [6];
    bits = 6'b100101;
    e_st = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(bits[5-i], 1'b1);
      ncmp++; if (st_ov !== e_st[i]) begin nerr++; $display("FAIL nfm_state bit%0d got %0d want %0d", i+1, st_ov, e_st[i]); end
      ncmp++; if (y_ov !== (i == 5)) begin nerr++; $display("FAIL nfm_y bit%0d got %b want %b", i+1, y_ov, i == 5); end
      ncmp++; if (y_one !== bits[5-i] || st_one !== bits[5-i]) begin nerr++; $display("FAIL len1 bit%0d got y=%b st=%b want %b", i+1, y_one, st_one, bits[5-i]); end
    end
  endtask

  task automatic test_enable_and_reset();
    do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    ncmp++; if (st_ov !== 2'd1) begin nerr++; $display("FAIL en_hold_a got %0d want 1", st_ov); end
    step(1'b1, 1'b0);
    ncmp++; if (st_ov !== 2'd1) begin nerr++; $display("FAIL en_hold_b got %0d want 1", st_ov); end
    step(1'b0, 1'b1);
    ncmp++; if (st_ov !== 2'd2) begin nerr++; $display("FAIL en_bit2 got %0d want 2", st_ov); end
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    ncmp++; if (st_ov !== 2'd3 || y_ov !== 1'b1) begin nerr++; $display("FAIL en_match got st=%0d y=%b want 3/1", st_ov, y_ov); end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    ncmp++; if (y_ov !== 1'b1) begin nerr++; $display("FAIL en_y_hold got %b want 1", y_ov); end
    ncmp++; if (cnt_ov !== (CNT_ON ? 8'd1 : 8'd0)) begin nerr++; $display("FAIL en_cnt got %0d want %0d", cnt_ov, CNT_ON ? 1 : 0); end
    // rst is pulsed between edges after "10"
    do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    ncmp++; if (st_ov !== 2'd0 || y_ov !== 1'b0) begin nerr++; $display("FAIL async_rst got st=%0d y=%b want 0/0", st_ov, y_ov); end
    #2;
    rst = 1'b0;
    step(1'b1, 1'b1);
    ncmp++; if (st_ov !== 2'd1 || y_ov !== 1'b0) begin nerr++; $display("FAIL post_rst got st=%0d y=%b want 1/0", st_ov, y_ov); end
  endtask

  // 10101010101 gives five overlapping matches. The 2-bit counter stops at 3.
  task automatic test_saturation();
    int m;
    m = 0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1);
      if (i >= 2 && (i % 2) == 0) m++;
      ncmp++; if (cnt_sat !== (CNT_ON ? 2'((m > 3) ? 3 : m) : 2'd0)) begin nerr++; $display("FAIL sat_cnt bit%0d got %0d want %0d", i+1, cnt_sat, CNT_ON ? ((m > 3) ? 3 : m) : 0); end
    end
    ncmp++; if (cnt_ov !== (CNT_ON ? 8'd5 : 8'd0)) begin nerr++; $display("FAIL sat_wide_cnt got %0d want %0d", cnt_ov, CNT_ON ? 5 : 0); end
  endtask

  // 500 random bits with A7 placed at known offsets. The model compares the
  // last 8 accepted bits with the pattern.
  task automatic test_random_a7();
    logic       bits [500];
    logic [7:0] pat;
    logic [7:0] hist;
    int         nacc;
    int         mcnt;
    int         offs [4];
    logic       ey;
    pat  = 8'hA7;
    offs = '{50, 130, 300, 490};
    hist = '0;
    nacc = 0;
    mcnt = 0;
    for (int i = 0; i < 500; i++) bits[i] = 1'($urandom_range(0, 1));
    for (int o = 0; o < 4; o++)
      for (int i = 0; i < 8; i++) bits[offs[o] + i] = pat[7-i];
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step(bits[i], 1'b1);
      hist = {hist[6:0], bits[i]};
      nacc++;
      ey = (nacc >= 8) && (hist == pat);
      if (ey) mcnt++;
      ncmp++; if (y_a7 !== ey) begin nerr++; $display("FAIL a7_y bit%0d got %b want %b", i, y_a7, ey); end
    end
    ncmp++; if (cnt_a7 !== (CNT_ON ? 8'(mcnt) : 8'd0)) begin nerr++; $display("FAIL a7_cnt got %0d want %0d", cnt_a7, CNT_ON ? mcnt : 0); end
  endtask

  initial begin
    test_reset();
    test_overlap_modes();
    test_no_false_match();
    test_enable_and_reset();
    test_saturation();
    test_random_a7();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
